// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one 8-stage pipelined 64-bit multiplier with a
// credit-protected result FIFO. Define MULT_ARB_CHECK_EN to build the done/tag checker.
module mult_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int LATENCY   = 8,
    parameter int RES_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*64-1:0]       req_mcand,
    input  logic [NUM_REQ*64-1:0]       req_mplier,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        mult_start,
    output logic [63:0]                 mult_mcand,
    output logic [63:0]                 mult_mplier,
    input  logic [63:0]                 mult_product,
    input  logic                        mult_done,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]  resp_id,
    output logic [63:0]                 resp_product,
    output logic [$clog2(RES_DEPTH):0]  in_flight,
    output logic                        protocol_err
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int PW  = $clog2(RES_DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(RES_DEPTH);
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(RES_DEPTH);

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   idx_sum;
    logic           found;
    logic           accept;
    logic           can_issue;
    logic [CW:0]    credit_sum;
    logic [63:0]    sel_mcand;
    logic [63:0]    sel_mplier;
    logic [IDW-1:0] issue_id;

    logic [LATENCY-1:0] tag_v;
    logic [IDW-1:0]     tag_id [LATENCY];
    logic [IDW-1:0]     push_id;

    logic [IDW-1:0] mem_id   [RES_DEPTH];
    logic [63:0]    mem_prod [RES_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  fifo_count;
    logic           push;
    logic           pop;

    // credit counts every result already owed a FIFO slot, so a non-stallable done never overflows
    assign credit_sum = {1'b0, in_flight} + {1'b0, fifo_count};
    assign can_issue  = credit_sum < DEPTH_W;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found   = 1'b0;
        idx_sum = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (idx_sum >= NREQ_W) idx_sum = idx_sum - NREQ_W;
            if (reset && can_issue && !found && req[idx_sum[IDW-1:0]]) begin
                found                     = 1'b1;
                gnt[idx_sum[IDW-1:0]]     = 1'b1;
                gnt_id                    = idx_sum[IDW-1:0];
            end
        end
    end

    assign accept = |gnt;

    always_comb begin
        sel_mcand  = '0;
        sel_mplier = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                sel_mcand  = req_mcand[k*64 +: 64];
                sel_mplier = req_mplier[k*64 +: 64];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr      <= '0;
            mult_start  <= 1'b0;
            mult_mcand  <= '0;
            mult_mplier <= '0;
            issue_id    <= '0;
        end else begin
            mult_start <= accept;
            if (accept) begin
                rr_ptr      <= (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                mult_mcand  <= sel_mcand;
                mult_mplier <= sel_mplier;
                issue_id    <= gnt_id;
            end
        end
    end

    // tag stage LATENCY-1 lines up with the multiplier's mult_done for the same operation
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_v <= '0;
            for (int i = 0; i < LATENCY; i++) tag_id[i] <= '0;
        end else begin
            tag_v     <= {tag_v[LATENCY-2:0], mult_start};
            tag_id[0] <= issue_id;
            for (int i = 1; i < LATENCY; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    assign push_id = tag_v[LATENCY-1] ? tag_id[LATENCY-1] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight <= '0;
        end else if (accept && !mult_done) begin
            in_flight <= in_flight + CW'(1);
        end else if (!accept && mult_done && in_flight != '0) begin
            in_flight <= in_flight - CW'(1);
        end
    end

    assign resp_valid = (fifo_count != '0);
    assign pop        = resp_valid && resp_ready;
    assign push       = mult_done && ((fifo_count != DEPTH_C) || pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + CW'(1);
            else if (!push && pop) fifo_count <= fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_id[wr_ptr]   <= push_id;
            mem_prod[wr_ptr] <= mult_product;
        end
    end

    assign resp_id      = resp_valid ? mem_id[rd_ptr]   : '0;
    assign resp_product = resp_valid ? mem_prod[rd_ptr] : '0;

`ifdef MULT_ARB_CHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            protocol_err <= 1'b0;
        end else if ((mult_done != tag_v[LATENCY-1]) ||
                     (mult_done && !accept && in_flight == '0)) begin
            protocol_err <= 1'b1;
        end
    end
`else
    assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural 8-stage multiplier attached.
module tb_mult_arbiter;
    logic          clock = 1'b0;
    logic          reset;
    logic [3:0]    req;
    logic [255:0]  req_mcand;
    logic [255:0]  req_mplier;
    logic [3:0]    gnt;
    logic          mult_start;
    logic [63:0]   mult_mcand;
    logic [63:0]   mult_mplier;
    logic [63:0]   mult_product;
    logic          mult_done;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [63:0]   resp_product;
    logic [4:0]    in_flight;
    logic          protocol_err;

    logic          inject_done;
    logic [63:0]   inject_val;
    logic [7:0]    mp_v;
    logic [63:0]   mp_prod [8];

    typedef struct packed {
        logic [1:0]  id;
        logic [63:0] p;
    } exp_t;

    exp_t sb_q [$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clock = ~clock;

    mult_arbiter dut (
        .clock(clock), .reset(reset), .req(req), .req_mcand(req_mcand),
        .req_mplier(req_mplier), .gnt(gnt), .mult_start(mult_start),
        .mult_mcand(mult_mcand), .mult_mplier(mult_mplier),
        .mult_product(mult_product), .mult_done(mult_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_product(resp_product), .in_flight(in_flight),
        .protocol_err(protocol_err)
    );

    // external multiplier: shares the arbiter's reset, so it never emits stale dones
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mp_v <= '0;
        end else begin
            mp_v       <= {mp_v[6:0], mult_start};
            mp_prod[0] <= mult_mcand * mult_mplier;
            for (int i = 1; i < 8; i++) mp_prod[i] <= mp_prod[i-1];
        end
    end
    assign mult_done    = mp_v[7] | inject_done;
    assign mult_product = inject_done ? inject_val : mp_prod[7];

    always @(negedge clock) begin
        if (reset && resp_valid && resp_ready) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL resp_unexpected: got id=%0d product=%h, required no response",
                         resp_id, resp_product);
            end else begin
                mon_e = sb_q.pop_front();
                if (resp_id !== mon_e.id || resp_product !== mon_e.p) begin
                    n_fail++;
                    $display("FAIL resp_data: got id=%0d product=%h, required id=%0d product=%h",
                             resp_id, resp_product, mon_e.id, mon_e.p);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b);
        req_mcand[i*64 +: 64]  = a;
        req_mplier[i*64 +: 64] = b;
    endtask

    task automatic expect_resp(input logic [1:0] id, input logic [63:0] p);
        exp_t e;
        e.id = id;
        e.p  = p;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name, input int lim);
        for (int c = 0; c < lim && sb_q.size() != 0; c++) @(negedge clock);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d responses outstanding, required 0", name, sb_q.size());
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_gnt"},       64'(gnt), 64'd0);
        check({name, "_start"},     64'(mult_start), 64'd0);
        check({name, "_mcand"},     mult_mcand, 64'd0);
        check({name, "_mplier"},    mult_mplier, 64'd0);
        check({name, "_valid"},     64'(resp_valid), 64'd0);
        check({name, "_id"},        64'(resp_id), 64'd0);
        check({name, "_product"},   resp_product, 64'd0);
        check({name, "_in_flight"}, 64'(in_flight), 64'd0);
        check({name, "_err"},       64'(protocol_err), 64'd0);
    endtask

    initial begin
        int    lat;
        int    n_acc;
        int    n_extra;
        int    k;
        bit    got;
        int    rr_prod [5];

        rr_prod     = '{10, 20, 30, 40, 10};
        reset       = 1'b0;
        req         = '0;
        req_mcand   = '0;
        req_mplier  = '0;
        resp_ready  = 1'b1;
        inject_done = 1'b0;
        inject_val  = '0;
        #2;
        check_all_zero("reset");
        #10 reset = 1'b1;
        tick();

        // round-robin, all requesters active
        for (int i = 0; i < 4; i++) set_ops(i, 64'(i + 1), 64'd10);
        req = 4'hF;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check("rr_gnt", 64'(gnt), 64'(4'b0001 << (n % 4)));
            expect_resp(2'(n % 4), 64'(rr_prod[n]));
            tick();
        end
        req = '0;
        drain("rr_drain", 60);

        // single op with latency measurement
        tick();
        set_ops(2, 64'd7, 64'd6);
        req = 4'b0100;
        @(negedge clock);
        check("single_gnt", 64'(gnt), 64'h4);
        expect_resp(2'd2, 64'd42);
        tick();
        req = '0;
        @(negedge clock);
        check("single_in_flight", 64'(in_flight), 64'd1);
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("single_latency", 64'(lat), 64'd10);
        drain("single_drain", 20);

        // low-64 wrap of the product
        tick();
        set_ops(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        req = 4'b0001;
        @(negedge clock);
        check("wrap_gnt", 64'(gnt), 64'h1);
        expect_resp(2'd0, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        req = '0;
        drain("wrap_drain", 30);

        // backpressure: credit limits to 16 outstanding
        tick();
        resp_ready = 1'b0;
        k = 1;
        set_ops(0, 64'(k), 64'd3);
        req = 4'b0001;
        n_acc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            got = 1'b0;
            if (gnt != '0) begin
                check("bp_gnt", 64'(gnt), 64'h1);
                expect_resp(2'd0, 64'(k * 3));
                n_acc++;
                k++;
                got = 1'b1;
            end
            tick();
            if (got) set_ops(0, 64'(k), 64'd3);
        end
        check("bp_accepts", 64'(n_acc), 64'd16);
        @(negedge clock);
        check("bp_gnt_blocked", 64'(gnt), 64'd0);
        check("bp_in_flight", 64'(in_flight), 64'd0);
        check("bp_valid", 64'(resp_valid), 64'd1);
        tick();
        resp_ready = 1'b1;
        n_extra = 0;
        for (int c = 0; c < 60 && n_extra < 4; c++) begin
            @(negedge clock);
            got = 1'b0;
            if (gnt != '0) begin
                expect_resp(2'd0, 64'(k * 3));
                n_extra++;
                k++;
                got = 1'b1;
            end
            tick();
            if (got) set_ops(0, 64'(k), 64'd3);
        end
        check("bp_resume_accepts", 64'(n_extra), 64'd4);
        req = '0;
        drain("bp_drain", 100);

        // async reset with 5 in flight and 3 buffered
        tick();
        resp_ready = 1'b0;
        set_ops(1, 64'd100, 64'd1);
        req = 4'b0010;
        n_acc = 0;
        for (int c = 0; c < 20 && n_acc < 8; c++) begin
            @(negedge clock);
            if (gnt != '0) n_acc++;
            tick();
        end
        req = '0;
        check("mid_accepts", 64'(n_acc), 64'd8);
        for (int c = 0; c < 20 && in_flight != 5'd5; c++) @(negedge clock);
        check("mid_in_flight", 64'(in_flight), 64'd5);
        check("mid_valid", 64'(resp_valid), 64'd1);
        #2;
        req   = 4'hF;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        sb_q.delete();
        @(posedge clock);
        #2;
        check("midrst_hold_start", 64'(mult_start), 64'd0);
        req        = '0;
        resp_ready = 1'b1;
        reset      = 1'b1;
        tick();
        set_ops(3, 64'd3, 64'd5);
        req = 4'b1000;
        @(negedge clock);
        check("post_rst_gnt", 64'(gnt), 64'h8);
        expect_resp(2'd3, 64'd15);
        tick();
        req = '0;
        drain("post_rst_drain", 30);
        repeat (15) @(negedge clock);

        // orphan mult_done
        tick();
        inject_val  = 64'h1234;
        inject_done = 1'b1;
        expect_resp(2'd0, 64'h1234);
        tick();
        inject_done = 1'b0;
        @(negedge clock);
`ifdef MULT_ARB_CHECK_EN
        check("chk_err_set", 64'(protocol_err), 64'd1);
        repeat (5) @(negedge clock);
        check("chk_err_sticky", 64'(protocol_err), 64'd1);
`else
        check("chk_err_absent", 64'(protocol_err), 64'd0);
        repeat (5) @(negedge clock);
        check("chk_err_absent_later", 64'(protocol_err), 64'd0);
`endif
        drain("chk_drain", 20);
        #2 reset = 1'b0;
        #1;
        check("chk_err_cleared", 64'(protocol_err), 64'd0);
        #10 reset = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one 8-stage pipelined 64-bit multiplier (start/done, low-64 product, no stall, no tag) between NUM_REQ requesters.
- Round-robin issue, one operation per cycle max; tracks requester ID alongside the pipeline.
- Buffers results in a credit-protected FIFO so requesters can apply backpressure even though the multiplier cannot stall.
- Sits between execution-unit request ports and the multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 8, cycles from mult_start high to matching mult_done high.
- RES_DEPTH, 16, result FIFO entries (power of 2, >= LATENCY).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request valid per requester; operands held stable until granted.
- req_mcand  in  NUM_REQ*64  multiplicand per requester; slice i = [64i+63:64i].
- req_mplier  in  NUM_REQ*64  multiplier per requester; same slicing.
- gnt  out  NUM_REQ  one-hot acceptance; req[i]&gnt[i] at a rising edge = accepted.
- mult_start  out  1  to multiplier start.
- mult_mcand  out  64  to multiplier mcand.
- mult_mplier  out  64  to multiplier mplier.
- mult_product  in  64  from multiplier product.
- mult_done  in  1  from multiplier done.
- resp_valid  out  1  FIFO head valid.
- resp_ready  in  1  consumer accepts head.
- resp_id  out  $clog2(NUM_REQ)  requester index of head.
- resp_product  out  64  product of head.
- in_flight  out  $clog2(RES_DEPTH)+1  operations issued, not yet in FIFO.
- protocol_err  out  1  sticky tag/done mismatch (see Optional Feature).

Behaviour:
- Reset (reset low, async): gnt=0, mult_start=0, mult_mcand=0, mult_mplier=0, resp_valid=0, resp_id=0, resp_product=0, in_flight=0, protocol_err=0. RR pointer=0, tag pipe cleared, FIFO empty. The multiplier is reset from the same source, so no stale mult_done can arrive after reset. Reset mid-operation discards all in-flight and buffered results.
- Credit: can_issue = (in_flight + fifo_count) < RES_DEPTH, from registered values only; no same-cycle pop bypass.
- Arbitration (combinational gnt): if can_issue, grant the first req[i] set, searching from RR pointer upward with wrap. gnt=0 when no req or no credit.
- On accept of i: RR pointer <= (i+1) mod NUM_REQ. Pointer is unchanged when nothing is accepted.
- Issue stage (registered): cycle after accept, mult_start=1 and mult_mcand/mult_mplier = operands of i. Otherwise mult_start=0 and operands hold their last value.
- Tag pipe: LATENCY-deep shift of {valid,id}, entered with mult_start, so each tag exits aligned with its mult_done.
- Accept-to-resp_valid latency = LATENCY+2 cycles with an empty FIFO (accept edge E, start in cycle E+1, done in cycle E+1+LATENCY, resp_valid from E+2+LATENCY).
- in_flight: +1 on accept, -1 on mult_done; both in the same cycle = unchanged.
- FIFO push on mult_done with {tag id, mult_product}. Full-push cannot occur by construction.
- FIFO pop on resp_valid&resp_ready. Pop when empty is ignored. Simultaneous push and pop are both honoured. Pointers wrap mod RES_DEPTH.
- Results leave in issue order. resp_id/resp_product are stable while resp_valid=1 and resp_ready=0.
- Back-to-back accepts every cycle are sustained while credit remains.

Optional Feature:
- MULT_ARB_CHECK_EN defined:
  - protocol_err is set when mult_done != exiting tag valid, or when in_flight would underflow.
  - Sticky until reset. On mismatch with mult_done=1, the result is still pushed with the tag id.
- Undefined: checker absent, protocol_err tied 0, push driven by mult_done alone.

Test Plan:
- Single op: req[2]=1, mcand=7, mplier=6 -> gnt=4'b0100 that cycle; resp_valid exactly 10 cycles after accept; resp_id=2, resp_product=42.
- Round-robin: req=4'b1111 held, resp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; resp_id order 0,1,2,3,0.
- Wrap/overflow product: mcand=64'hFFFF_FFFF_FFFF_FFFF, mplier=2 -> resp_product=64'hFFFF_FFFF_FFFF_FFFE.
- Backpressure: resp_ready=0, req[0] continuous -> exactly 16 accepts, then gnt=0, in_flight=0, FIFO full. Raising resp_ready restores one grant per pop, with no loss and no reordering.
- Async reset mid-stream: drop reset with 5 in flight and 3 buffered -> all outputs 0 immediately. After release, a new op (3×5) returns 15 with resp_id correct and no stale responses.
- Checker (MULT_ARB_CHECK_EN): inject mult_done with no issued op -> protocol_err=1 next cycle and stays 1 until reset. Without the macro, protocol_err stays 0.
